// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and constants for the UART transmit arbiter:
//               FSM state encoding, tag-byte layout and requester limit.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Largest supported requester count
    localparam int c_MAX_NUM_REQ = 8;

    // Tag byte layout: {nibble[3:0], 1'b0, id[2:0]}
    localparam int c_TAG_NIB_W = 4;
    localparam int c_TAG_ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Assemble the tag byte announcing which requester owns the link
    function automatic logic [7:0] make_tag(
        input logic [c_TAG_NIB_W-1:0] nibble,
        input logic [c_TAG_ID_W-1:0]  id
    );
        return {nibble, 1'b0, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Round-robin requester selection. Searches the valid vector
//               upward from the pointer, wrapping modulo NUM_REQ, and returns
//               the first hit as one-hot, as an index, and an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_valid
);

    localparam logic [IDX_W:0] c_NUM = (IDX_W+1)'(NUM_REQ);

    // One spare bit so ptr + offset never overflows before the wrap
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;

    // Walk candidates in priority order ptr, ptr+1, ... and keep the first valid
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!o_any_valid && i_valid[w_idx]) begin
                o_any_valid        = 1'b1;
                o_grant_idx        = w_idx;
                o_grant_oh[w_idx]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NUM_REQ byte sources.
//               Round-robin grant in IDLE, one-cycle trigger in LAUNCH, then
//               waits for the transmitter busy pulse to rise and fall.
//               Optional feature macro UART_TX_ARBITER_TAG_EN: each grant
//               sends a tag byte {TAG_NIBBLE, 0, id} before the data byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter logic [3:0] TAG_NIBBLE = 4'hA
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [8*NUM_REQ-1:0]       req_data_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic [7:0]                 uart_data_out,
    output logic                       uart_trigger_out,
    input  logic                       uart_busy_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_out,
    output logic                       active_out
);

    localparam int                c_ID_W     = $clog2(NUM_REQ);
    localparam logic [c_ID_W-1:0] c_LAST_IDX = c_ID_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > c_MAX_NUM_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [7:0]          r_data;

    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [c_ID_W-1:0]   w_grant_idx;
    logic                w_any_valid;
    logic                w_transfer;
    logic [7:0]          w_sel_byte;
    logic [c_ID_W-1:0]   w_ptr_next;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_trigger;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_ID_W)
    ) u_rr_picker (
        .i_valid     (req_valid_in),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    // A transfer happens on any edge where IDLE offers ready to a valid requester
    assign w_transfer = (r_state == IDLE) && w_any_valid;
    assign w_ptr_next = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + c_ID_W'(1);

    // Select the granted requester's byte via the one-hot grant
    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_byte = w_sel_byte | req_data_in[8*i +: 8];
            end
        end
    end

`ifdef UART_TX_ARBITER_TAG_EN
    logic       r_tag_pending;
    logic [7:0] r_uart_data;
    logic       w_tag_to_data;

    // Leaving WAIT_DONE with the tag done means the data byte goes next
    assign w_tag_to_data = (r_state == WAIT_DONE) && !uart_busy_in && r_tag_pending;
`else
    // The tag nibble only matters in the tagged build
    logic w_unused_tag_nibble;
    assign w_unused_tag_nibble = ^TAG_NIBBLE;
`endif

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, ready and trigger decode; a trigger never fires while busy
    always_comb begin
        w_next_state = r_state;
        w_ready      = '0;
        w_trigger    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst_n_in) begin
                    w_ready = w_grant_oh;
                end
                if (w_any_valid) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!uart_busy_in) begin
                    w_trigger    = 1'b1;
                    w_next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (uart_busy_in) begin
                    w_next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy_in) begin
`ifdef UART_TX_ARBITER_TAG_EN
                    w_next_state = r_tag_pending ? LAUNCH : IDLE;
`else
                    w_next_state = IDLE;
`endif
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Capture pointer, owner id and byte on the transfer edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_data     <= '0;
        end else if (w_transfer) begin
            r_ptr      <= w_ptr_next;
            r_grant_id <= w_grant_idx;
            r_data     <= w_sel_byte;
        end
    end

`ifdef UART_TX_ARBITER_TAG_EN
    // Tag goes out first; the captured byte replaces it for the second launch
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tag_pending <= 1'b0;
            r_uart_data   <= '0;
        end else if (w_transfer) begin
            r_tag_pending <= 1'b1;
            r_uart_data   <= make_tag(TAG_NIBBLE, c_TAG_ID_W'(w_grant_idx));
        end else if (w_tag_to_data) begin
            r_tag_pending <= 1'b0;
            r_uart_data   <= r_data;
        end
    end

    assign uart_data_out = r_uart_data;
`else
    assign uart_data_out = r_data;
`endif

    assign req_ready_out    = w_ready;
    assign uart_trigger_out = w_trigger;
    assign grant_id_out     = r_grant_id;
    assign active_out       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NUM_REQ=4) with a
//               transmitter model whose busy rises one cycle after a trigger
//               and lasts 10 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_LEN = 10;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [1:0] id;
    } trig_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_id;
        logic [7:0]  exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [7:0]  udata;
    logic        trig;
    logic        busy;
    logic [1:0]  gid;
    logic        active;
    logic        force_busy;
    int          busy_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [3:0]  clr_mask = '0;
    bit          auto_clear = 1'b1;
    int          xfer_cnt [N];
    int          last_xfer_cyc = 0;
    int          prev_pop_cyc = -1;
    int          busy_viol = 0;
    int          ready_viol = 0;
    trig_t       tq [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .TAG_NIBBLE (4'hA)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .req_valid_in     (valid),
        .req_data_in      (data),
        .req_ready_out    (ready),
        .uart_data_out    (udata),
        .uart_trigger_out (trig),
        .uart_busy_in     (busy),
        .grant_id_out     (gid),
        .active_out       (active)
    );

    // Transmitter model: busy for BUSY_LEN cycles starting the cycle after a trigger
    assign busy = force_busy || (busy_cnt != 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             busy_cnt <= 0;
        else if (trig)          busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_min(input string name, input int act, input int min);
        n_vec++;
        if (act < min) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    // One clock: sample mid-cycle, then let the edge happen and retire served requests
    task automatic step();
        @(negedge clk);
        cyc++;
        clr_mask = '0;
        if (rst_n) begin
            clr_mask = ready & valid;
            for (int i = 0; i < N; i++) begin
                if (clr_mask[i]) begin
                    xfer_cnt[i]++;
                    last_xfer_cyc = cyc;
                end
            end
            if ($countones(ready) > 1) ready_viol++;
            if (trig) begin
                tq.push_back('{cyc, udata, gid});
                if (busy) busy_viol++;
            end
        end
        @(posedge clk);
        #1;
        if (auto_clear) valid = valid & ~clr_mask;
    endtask

    task automatic pop_trig(input string name, input bit gap_chk, output trig_t t, output bit ok);
        int n = 0;
        while (tq.size() == 0 && n < 200) begin
            step();
            n++;
        end
        if (tq.size() == 0) begin
            ok = 1'b0;
            t  = '{0, 8'h00, 2'd0};
            n_vec++;
            n_bad++;
            $display("FAIL %s: no trigger within 200 cycles", name);
        end else begin
            ok = 1'b1;
            t  = tq.pop_front();
            if (gap_chk && prev_pop_cyc >= 0)
                chk_min({name, "_gap"}, t.cyc - prev_pop_cyc, BUSY_LEN + 2);
            prev_pop_cyc = t.cyc;
        end
    endtask

    // One grant's worth of triggers: optional tag byte, then the data byte
    task automatic expect_frame(input string name, input logic [1:0] id, input logic [7:0] d,
                                input bit gap_chk, output int first_cyc);
        trig_t t;
        bit    ok;
        first_cyc = -1;
`ifdef UART_TX_ARBITER_TAG_EN
        pop_trig(name, gap_chk, t, ok);
        if (ok) begin
            first_cyc = t.cyc;
            chk({name, "_tag"}, 32'(t.data), 32'(8'hA0 | 8'(id)));
            chk({name, "_tagid"}, 32'(t.id), 32'(id));
        end
`endif
        pop_trig(name, gap_chk, t, ok);
        if (ok) begin
            if (first_cyc < 0) first_cyc = t.cyc;
            chk({name, "_data"}, 32'(t.data), 32'(d));
            chk({name, "_id"}, 32'(t.id), 32'(id));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        step();
        while (active && n < 200) begin
            step();
            n++;
        end
        if (active) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: still active after 200 cycles", name);
        end
    endtask

    task automatic clear_xfer();
        for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
    endtask

    vec_t vt [8];

    initial begin
        int fc;
        int rel_cyc;

        // ptr sequence through the table: 0 ->3 ->1 ->2 ->0 ->1 ->3 ->1 ->0
        vt[0] = '{4'b0100, 32'h005C_0000, 2'd2, 8'h5C};
        vt[1] = '{4'b0001, 32'h0000_00A1, 2'd0, 8'hA1};
        vt[2] = '{4'b1010, 32'hB300_B100, 2'd1, 8'hB1};
        vt[3] = '{4'b1010, 32'hC300_C100, 2'd3, 8'hC3};
        vt[4] = '{4'b1111, 32'hD3D2_D1D0, 2'd0, 8'hD0};
        vt[5] = '{4'b1100, 32'hE3E2_0000, 2'd2, 8'hE2};
        vt[6] = '{4'b0111, 32'h00F2_F1F0, 2'd0, 8'hF0};
        vt[7] = '{4'b1000, 32'h9900_0000, 2'd3, 8'h99};

        rst_n      = 1'b0;
        valid      = 4'b1111;
        data       = 32'h1234_5678;
        force_busy = 1'b0;
        clear_xfer();
        #2;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_trig", 32'(trig), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_udata", 32'(udata), 32'h0);
        chk("rst_gid", 32'(gid), 32'h0);
        repeat (3) step();
        valid = '0;
        rst_n = 1'b1;
        step();

        // Table: one grant per vector, unserved requesters withdrawn afterwards
        for (int i = 0; i < 8; i++) begin
            clear_xfer();
            valid = vt[i].valid;
            data  = vt[i].data;
            expect_frame($sformatf("v%0d", i), vt[i].exp_id, vt[i].exp_data, 1'b0, fc);
            valid = '0;
            chk($sformatf("v%0d_lat", i), 32'(fc - last_xfer_cyc), 32'd1);
            wait_idle($sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_xfers", i),
                32'(xfer_cnt[0] + xfer_cnt[1] + xfer_cnt[2] + xfer_cnt[3]), 32'd1);
            if (i == 0) chk("v0_ready_bit2", 32'(xfer_cnt[2]), 32'd1);
        end

        // All four continuously valid: order 0,1,2,3,0 with full spacing
        auto_clear   = 1'b0;
        prev_pop_cyc = -1;
        valid = 4'b1111;
        data  = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            expect_frame($sformatf("rr%0d", k), 2'(k % 4), 8'(8'h10 + (k % 4)), 1'b1, fc);
        end
        valid      = '0;
        auto_clear = 1'b1;
        wait_idle("rr_idle");

        // Busy already high: accept the byte but hold the launch until busy drops
        force_busy = 1'b1;
        repeat (20) step();
        clear_xfer();
        valid = 4'b0010;
        data  = 32'h0000_7700;
        repeat (8) step();
        chk("busy_accept", 32'(xfer_cnt[1]), 32'd1);
        chk("busy_stall", 32'(tq.size()), 32'd0);
        chk("busy_active", 32'(active), 32'd1);
        rel_cyc    = cyc;
        force_busy = 1'b0;
        prev_pop_cyc = -1;
        expect_frame("busy", 2'd1, 8'h77, 1'b0, fc);
        chk_min("busy_after_release", fc - rel_cyc, 1);
        wait_idle("busy_idle");

        // Reset in the middle of WAIT_DONE, then requester 0 must win first
        valid = 4'b0100;
        data  = 32'h005A_0000;
        expect_frame("pre_rst", 2'd2, 8'h5A, 1'b0, fc);
        repeat (4) step();
        chk("pre_rst_active", 32'(active), 32'd1);
        #2;
        rst_n = 1'b0;
        valid = 4'b1111;
        data  = 32'h4433_2211;
        #1;
        chk("midrst_active", 32'(active), 32'h0);
        chk("midrst_udata", 32'(udata), 32'h0);
        chk("midrst_gid", 32'(gid), 32'h0);
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_trig", 32'(trig), 32'h0);
        repeat (3) step();
        tq.delete();
        rst_n = 1'b1;
        prev_pop_cyc = -1;
        expect_frame("post_rst", 2'd0, 8'h11, 1'b0, fc);
        valid = '0;
        wait_idle("post_rst_idle");

        // Bring ptr to 2, then requesters 1 and 3 together wrap: 3 first, then 1
        valid = 4'b0010;
        data  = 32'h0000_4400;
        expect_frame("ptr_set", 2'd1, 8'h44, 1'b0, fc);
        wait_idle("ptr_set_idle");
        valid = 4'b1010;
        data  = 32'h3300_1100;
        expect_frame("wrap_a", 2'd3, 8'h33, 1'b0, fc);
        expect_frame("wrap_b", 2'd1, 8'h11, 1'b0, fc);
        wait_idle("wrap_idle");

        // Requester 3 with others waiting: no other grant inside its frame
        clear_xfer();
        valid = 4'b1011;
        data  = 32'hFF00_2120;
        expect_frame("owner3", 2'd3, 8'hFF, 1'b0, fc);
        chk("owner3_others", 32'(xfer_cnt[0] + xfer_cnt[1]), 32'd0);
        valid = '0;
        wait_idle("owner3_idle");

        chk("trig_while_busy", 32'(busy_viol), 32'd0);
        chk("ready_onehot", 32'(ready_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
